// File: rtl/axi4l_pkg.sv
// AXI4-Lite shared types, response codes and a response classification helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
`timescale 1ns/1ps
package axi4l_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [DATA_W/8-1:0] strb_t;
    typedef logic [1:0]          resp_t;
    typedef logic [2:0]          prot_t;

    localparam resp_t OKAY   = 2'b00;
    localparam resp_t EXOKAY = 2'b01;
    localparam resp_t SLVERR = 2'b10;
    localparam resp_t DECERR = 2'b11;

    // Anything other than OKAY is reported to the core as a bus error.
    function automatic logic resp_is_err(input resp_t resp);
        return resp != OKAY;
    endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle with master and slave views; aclk is the shared system clock.
// Latency: none (wires only).
// Backpressure: standard valid/ready on every channel.
`timescale 1ns/1ps
interface axi4l_if (
    input logic aclk
);
    import axi4l_pkg::*;

    addr_t awaddr;
    prot_t awprot;
    logic  awvalid;
    logic  awready;
    data_t wdata;
    strb_t wstrb;
    logic  wvalid;
    logic  wready;
    resp_t bresp;
    logic  bvalid;
    logic  bready;
    addr_t araddr;
    prot_t arprot;
    logic  arvalid;
    logic  arready;
    data_t rdata;
    resp_t rresp;
    logic  rvalid;
    logic  rready;

    modport master (
        input  aclk,
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  aclk,
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );

endinterface

// File: rtl/ibex_axi4l_bridge.sv
// Ibex req/gnt/rvalid port to AXI4-Lite master, one transaction outstanding.
// Latency: grant cycle 0, AW/W/AR valid cycle 1, response cycle 2 minimum, rvalid_o cycle 3.
// Backpressure: gnt_o only in IDLE; AXI valids are registered and held until their own ready.
`timescale 1ns/1ps
module ibex_axi4l_bridge
    import axi4l_pkg::*;
#(
    parameter prot_t PROT = 3'b000
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    req_i,
    output logic    gnt_o,
    output logic    rvalid_o,
    input  logic    we_i,
    input  strb_t   be_i,
    input  addr_t   addr_i,
    input  data_t   wdata_i,
    output data_t   rdata_o,
    output logic    err_o,
    axi4l_if.master axi
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR_DATA,
        WRESP,
        RADDR,
        RRESP
    } state_e;

    state_e state_q, state_d;

    // Registered request: the AXI side never sees the live core inputs.
    addr_t addr_q;
    data_t wdata_q;
    strb_t be_q;

    logic  awvalid_q, awvalid_d;
    logic  wvalid_q,  wvalid_d;
    logic  arvalid_q, arvalid_d;
    logic  rvalid_q,  rvalid_d;
    logic  err_q,     err_d;
    data_t rdata_q,   rdata_d;
    logic  grant;

    // Next-state, grant and handshake bookkeeping; valids are only ever taken from flops.
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rvalid_d  = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        grant     = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant = req_i && !reset;
                if (grant) begin
                    if (we_i) begin
                        state_d   = WADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WADDR_DATA: begin
                // AW and W retire independently; move on once neither is pending.
                awvalid_d = awvalid_q && !axi.awready;
                wvalid_d  = wvalid_q && !axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (axi.bvalid) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    err_d    = resp_is_err(axi.bresp);
                end
            end
            RADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RRESP;
                end
            end
            RRESP: begin
                if (axi.rvalid) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    err_d    = resp_is_err(axi.rresp);
                    rdata_d  = axi.rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, channel valids and response registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            if (grant) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                be_q    <= be_i;
            end
        end
    end

    assign gnt_o       = grant;
    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;

    assign axi.awaddr  = addr_q;
    assign axi.awprot  = PROT;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = be_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = (state_q == WRESP);
    assign axi.araddr  = addr_q;
    assign axi.arprot  = PROT;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = (state_q == RRESP);

endmodule

// File: tb/tb_ibex_axi4l_bridge.sv
// Directed bench for the Ibex to AXI4-Lite bridge with a small memory-backed slave.
// Latency: slave answers in the cycle after the last request handshake unless delayed.
// Backpressure: awready and rvalid delays are programmable per test.
`timescale 1ns/1ps
module tb_ibex_axi4l_bridge;
    import axi4l_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  req_i;
    logic  gnt_o;
    logic  rvalid_o;
    logic  we_i;
    strb_t be_i;
    addr_t addr_i;
    data_t wdata_i;
    data_t rdata_o;
    logic  err_o;

    axi4l_if axi_bus (.aclk(clk));

    ibex_axi4l_bridge #(.PROT(3'b100)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .axi      (axi_bus)
    );

    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    data_t mem [0:15];
    int    aw_delay = 0;
    int    r_delay  = 0;
    resp_t resp_cfg = OKAY;
    int    aw_wait  = 0;
    int    r_cnt    = 0;
    int    wr_count_10 = 0;
    logic  have_aw, have_w, r_pend;
    addr_t aw_addr_s, ar_addr_s;
    data_t w_dat_s;
    strb_t w_strb_s;

    assign axi_bus.awready = axi_bus.awvalid && (aw_wait >= aw_delay);
    assign axi_bus.wready  = axi_bus.wvalid;
    assign axi_bus.arready = axi_bus.arvalid;

    function automatic data_t merge(input data_t old, input data_t nw, input strb_t s);
        data_t r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge axi_bus.aclk) begin : slave
        addr_t wa;
        data_t wd;
        strb_t ws;
        logic  aw_now, w_now;
        if (reset) begin
            have_aw <= 1'b0;
            have_w  <= 1'b0;
            r_pend  <= 1'b0;
            aw_wait <= 0;
            axi_bus.bvalid <= 1'b0;
            axi_bus.bresp  <= OKAY;
            axi_bus.rvalid <= 1'b0;
            axi_bus.rresp  <= OKAY;
            axi_bus.rdata  <= '0;
        end else begin
            aw_now = axi_bus.awvalid && axi_bus.awready;
            w_now  = axi_bus.wvalid && axi_bus.wready;
            if (aw_now) aw_wait <= 0;
            else if (axi_bus.awvalid) aw_wait <= aw_wait + 1;
            wa = have_aw ? aw_addr_s : axi_bus.awaddr;
            wd = have_w ? w_dat_s : axi_bus.wdata;
            ws = have_w ? w_strb_s : axi_bus.wstrb;
            if (axi_bus.bvalid && axi_bus.bready) axi_bus.bvalid <= 1'b0;
            if ((have_aw || aw_now) && (have_w || w_now)) begin
                mem[wa[5:2]] <= merge(mem[wa[5:2]], wd, ws);
                if (wa == 32'h10) wr_count_10 <= wr_count_10 + 1;
                axi_bus.bvalid <= 1'b1;
                axi_bus.bresp  <= resp_cfg;
                have_aw <= 1'b0;
                have_w  <= 1'b0;
            end else begin
                if (aw_now) begin have_aw <= 1'b1; aw_addr_s <= axi_bus.awaddr; end
                if (w_now)  begin have_w <= 1'b1; w_dat_s <= axi_bus.wdata; w_strb_s <= axi_bus.wstrb; end
            end
            if (axi_bus.rvalid && axi_bus.rready) axi_bus.rvalid <= 1'b0;
            if (axi_bus.arvalid && axi_bus.arready) begin
                if (r_delay == 0) begin
                    axi_bus.rvalid <= 1'b1;
                    axi_bus.rdata  <= mem[axi_bus.araddr[5:2]];
                    axi_bus.rresp  <= resp_cfg;
                end else begin
                    r_pend    <= 1'b1;
                    r_cnt     <= r_delay;
                    ar_addr_s <= axi_bus.araddr;
                end
            end else if (r_pend) begin
                if (r_cnt == 1) begin
                    axi_bus.rvalid <= 1'b1;
                    axi_bus.rdata  <= mem[ar_addr_s[5:2]];
                    axi_bus.rresp  <= resp_cfg;
                    r_pend <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1;
                end
            end
        end
    end

    // ---------------- cycle monitor ----------------
    int cyc = 0;
    int aw_first = -1, w_first = -1, ar_first = -1, b_first = -1;
    int aw_last = -1, w_last = -1, aw_hs = -1;
    int rv_count = 0;
    int t_g = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (axi_bus.awvalid) begin
            if (aw_first < 0) aw_first = cyc;
            aw_last = cyc;
            if (axi_bus.awready) aw_hs = cyc;
        end
        if (axi_bus.wvalid) begin
            if (w_first < 0) w_first = cyc;
            w_last = cyc;
        end
        if (axi_bus.arvalid && ar_first < 0) ar_first = cyc;
        if (axi_bus.bready && b_first < 0) b_first = cyc;
        if (rvalid_o) rv_count++;
    end

    task automatic clear_marks();
        aw_first = -1; w_first = -1; ar_first = -1; b_first = -1;
        aw_last  = -1; w_last  = -1; aw_hs    = -1;
    endtask

    // One core transaction; inputs are scrambled after the grant to prove they were registered.
    task automatic txn(input logic we, input addr_t a, input data_t d, input strb_t be,
                       output int lat, output data_t rd, output logic er);
        int n;
        clear_marks();
        @(negedge clk);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d; be_i = be;
        #1;
        check("gnt_idle", 64'(gnt_o), 64'(1));
        t_g = cyc;
        @(negedge clk);
        req_i = 1'b0; we_i = ~we; addr_i = 32'hBAD0_0004; wdata_i = 32'h5A5A_5A5A; be_i = 4'b1010;
        #1;
        n = 1;
        while (!rvalid_o && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check("rvalid_seen", 64'(rvalid_o), 64'(1));
        lat = n;
        rd  = rdata_o;
        er  = err_o;
        @(negedge clk); #1;
        check("rvalid_pulse", 64'(rvalid_o), 64'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed vectors ----------------
    initial begin : stim
        int    lat, n, c, g, gnt_early;
        data_t rd;
        logic  er;

        reset = 1'b1; req_i = 1'b1; we_i = 1'b1; be_i = '1; addr_i = 32'h10; wdata_i = '1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt",    64'(gnt_o), 64'(0));
        check("rst_rvalid", 64'(rvalid_o), 64'(0));
        check("rst_err",    64'(err_o), 64'(0));
        check("rst_rdata",  64'(rdata_o), 64'(0));
        check("rst_axi",    64'({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid,
                                 axi_bus.bready, axi_bus.rready}), 64'(0));
        req_i = 1'b0; reset = 1'b0;
        check("awprot", 64'(axi_bus.awprot), 64'(3'b100));
        check("arprot", 64'(axi_bus.arprot), 64'(3'b100));

        // Zero-wait write then readback.
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, lat, rd, er);
        check("wr_aw_cyc",  64'(aw_first - t_g), 64'(1));
        check("wr_w_cyc",   64'(w_first - t_g), 64'(1));
        check("wr_b_cyc",   64'(b_first - t_g), 64'(2));
        check("wr_lat",     64'(lat), 64'(3));
        check("wr_err",     64'(er), 64'(0));
        txn(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
        check("rd_ar_cyc",  64'(ar_first - t_g), 64'(1));
        check("rd_lat",     64'(lat), 64'(3));
        check("rd_data",    64'(rd), 64'(32'hDEAD_BEEF));
        check("rd_err",     64'(er), 64'(0));

        // Staggered write: awready held low for three cycles.
        aw_delay = 3;
        c = wr_count_10;
        txn(1'b1, 32'h10, 32'hCAFE_0001, 4'b1111, lat, rd, er);
        aw_delay = 0;
        check("stg_w_last",  64'(w_last - t_g), 64'(1));
        check("stg_aw_hs",   64'(aw_hs - t_g), 64'(4));
        check("stg_aw_last", 64'(aw_last - t_g), 64'(4));
        check("stg_lat",     64'(lat), 64'(6));
        check("stg_writes",  64'(wr_count_10 - c), 64'(1));
        check("wr_rdata_hold", 64'(rd), 64'(32'hDEAD_BEEF));
        txn(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
        check("stg_readback", 64'(rd), 64'(32'hCAFE_0001));

        // Byte-lane write into a populated word.
        txn(1'b1, 32'h20, 32'h1122_3344, 4'b1111, lat, rd, er);
        txn(1'b1, 32'h20, 32'h00AB_0000, 4'b0100, lat, rd, er);
        txn(1'b0, 32'h20, 32'h0, 4'b0000, lat, rd, er);
        check("byte_readback", 64'(rd), 64'(32'h11AB_3344));

        // Read stall with a second read held on req_i.
        txn(1'b1, 32'h30, 32'h5566_7788, 4'b1111, lat, rd, er);
        txn(1'b1, 32'h34, 32'h99AA_BBCC, 4'b1111, lat, rd, er);
        r_delay = 5;
        clear_marks();
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h30;
        #1;
        check("stall_gnt0", 64'(gnt_o), 64'(1));
        g = cyc;
        @(negedge clk);
        addr_i = 32'h34;
        #1;
        n = 1; gnt_early = 0;
        while (!rvalid_o && n < 40) begin
            if (gnt_o) gnt_early++;
            @(negedge clk); #1; n++;
        end
        check("stall_rvalid",  64'(rvalid_o), 64'(1));
        check("stall_no_gnt",  64'(gnt_early), 64'(0));
        check("stall_lat",     64'(n), 64'(8));
        check("stall_rdata",   64'(rdata_o), 64'(32'h5566_7788));
        check("stall_b2b_gnt", 64'(gnt_o), 64'(1));
        r_delay = 0;
        g = cyc;
        @(negedge clk);
        req_i = 1'b0;
        #1;
        n = 1;
        while (!rvalid_o && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check("b2b_rvalid", 64'(rvalid_o), 64'(1));
        check("b2b_lat",    64'(n), 64'(3));
        check("b2b_rdata",  64'(rdata_o), 64'(32'h99AA_BBCC));

        // Error responses.
        resp_cfg = SLVERR;
        txn(1'b0, 32'h30, 32'h0, 4'b0000, lat, rd, er);
        check("slverr_err", 64'(er), 64'(1));
        resp_cfg = OKAY;
        txn(1'b0, 32'h34, 32'h0, 4'b0000, lat, rd, er);
        check("okay_err",   64'(er), 64'(0));
        check("okay_rdata", 64'(rd), 64'(32'h99AA_BBCC));
        resp_cfg = DECERR;
        txn(1'b1, 32'h38, 32'h1234_5678, 4'b1111, lat, rd, er);
        check("decerr_err",  64'(er), 64'(1));
        check("decerr_hold", 64'(rd), 64'(32'h99AA_BBCC));
        resp_cfg = OKAY;

        // Reset while waiting in the read response state.
        r_delay = 3;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h30;
        @(negedge clk);
        req_i = 1'b0;
        @(negedge clk);
        #1;
        check("pre_rst_rready", 64'(axi_bus.rready), 64'(1));
        reset = 1'b1; req_i = 1'b1;
        c = rv_count;
        @(negedge clk);
        #1;
        check("mid_rst_gnt",    64'(gnt_o), 64'(0));
        check("mid_rst_rvalid", 64'(rvalid_o), 64'(0));
        check("mid_rst_err",    64'(err_o), 64'(0));
        check("mid_rst_rdata",  64'(rdata_o), 64'(0));
        check("mid_rst_axi",    64'({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid,
                                     axi_bus.bready, axi_bus.rready}), 64'(0));
        reset = 1'b0; req_i = 1'b0; r_delay = 0;
        repeat (8) @(negedge clk);
        #1;
        check("mid_rst_no_rvalid", 64'(rv_count - c), 64'(0));
        txn(1'b0, 32'h34, 32'h0, 4'b0000, lat, rd, er);
        check("post_rst_lat",   64'(lat), 64'(3));
        check("post_rst_rdata", 64'(rd), 64'(32'h99AA_BBCC));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
